// File: rtl/hazard_uart_sched_pkg.sv
// Shared definitions for the UART hazard scheduler: FSM state codes,
// memory-mapped addresses the decoder matches against, and the counter width default.
// Ports: none (package).
package hazard_uart_sched_pkg;

  localparam int CNT_W_DEF = 32;

  // MMIO addresses decoded upstream into ld_rx_y / st_tx_y / cnt_clr_y.
  localparam logic [31:0] MMIO_RX_DATA = 32'h8000_0004;
  localparam logic [31:0] MMIO_TX_DATA = 32'h8000_0008;
  localparam logic [31:0] MMIO_CNT_CLR = 32'h8000_0018;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_RX = 2'd1,
    ST_WAIT_TX = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

endpackage

// File: rtl/perf_cnt_pair.sv
// Cycle and retired-instruction counters with a shared synchronous clear.
// Ports: clk, rst (sync active-low), ins_inc, clr in; cyc_cnt, ins_cnt out.
// Both counters wrap silently; clear takes priority over increment.
module perf_cnt_pair #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ins_inc,
  input  logic         clr,
  output logic [W-1:0] cyc_cnt,
  output logic [W-1:0] ins_cnt
);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      // cycle counter runs through stalls; only reset or clear stops it
      cyc_cnt <= cyc_cnt + 1'b1;
      if (ins_inc) ins_cnt <= ins_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_uart_sched.sv
// Pipeline hazard scheduler for blocking UART MMIO accesses in stage Y.
// Ports: clk, rst (sync active-low), stall, valid_y, ld_rx_y, st_tx_y, cnt_clr_y,
// rx_valid, tx_ready, cnt_sel in; pc_en, xy_en, yz_en, yz_bubble, rx_pop, tx_push, cnt_out, state out.
module hazard_uart_sched
  import hazard_uart_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        valid_y,
  input  logic        ld_rx_y,
  input  logic        st_tx_y,
  input  logic        cnt_clr_y,
  input  logic        rx_valid,
  input  logic        tx_ready,
  input  logic        cnt_sel,
  output logic        pc_en,
  output logic        xy_en,
  output logic        yz_en,
  output logic        yz_bubble,
  output logic        rx_pop,
  output logic        tx_push,
  output logic [31:0] cnt_out,
  output logic [1:0]  state
);

  state_t state_q, state_d;
  logic   rx_req, tx_req;
  logic   ins_inc, cnt_clr;
  logic [CNT_W-1:0] cyc_cnt, ins_cnt;

  // RX has priority when a decode raises both flags at once.
  assign rx_req = valid_y & ld_rx_y;
  assign tx_req = valid_y & st_tx_y & ~ld_rx_y;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_BAD) begin
      state_d = ST_RUN;
    end else if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (rx_req && !rx_valid)      state_d = ST_WAIT_RX;
          else if (tx_req && !tx_ready) state_d = ST_WAIT_TX;
        end
        ST_WAIT_RX: if (rx_valid) state_d = ST_RUN;
        ST_WAIT_TX: if (tx_ready) state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_en     = 1'b0;
    xy_en     = 1'b0;
    yz_en     = 1'b0;
    yz_bubble = 1'b0;
    rx_pop    = 1'b0;
    tx_push   = 1'b0;
    if (rst && !stall) begin
      case (state_q)
        ST_RUN: begin
          if ((rx_req && !rx_valid) || (tx_req && !tx_ready)) begin
            // hold PC and Y, let Z drain a bubble while the UART is not ready
            yz_en     = 1'b1;
            yz_bubble = 1'b1;
          end else begin
            pc_en   = 1'b1;
            xy_en   = 1'b1;
            yz_en   = 1'b1;
            rx_pop  = rx_req;
            tx_push = tx_req;
          end
        end
        ST_WAIT_RX, ST_WAIT_TX: begin
          if ((state_q == ST_WAIT_RX) ? rx_valid : tx_ready) begin
            pc_en   = 1'b1;
            xy_en   = 1'b1;
            yz_en   = 1'b1;
            rx_pop  = (state_q == ST_WAIT_RX);
            tx_push = (state_q == ST_WAIT_TX);
          end else begin
            yz_en     = 1'b1;
            yz_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ins_inc = yz_en & ~yz_bubble & valid_y;
  assign cnt_clr = ins_inc & cnt_clr_y;

  perf_cnt_pair #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .ins_inc (ins_inc),
    .clr     (cnt_clr),
    .cyc_cnt (cyc_cnt),
    .ins_cnt (ins_cnt)
  );

  always_comb begin
    cnt_out = 32'd0;
    if (rst) cnt_out = cnt_sel ? 32'(ins_cnt) : 32'(cyc_cnt);
  end

  assign state = state_q;

endmodule
